// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART state encoding, parity modes and baud divisor helper
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick : bit-period counter, 1-cycle tick on the last clock of a bit
// Revision : 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;

    // Wrapping on the tick keeps every bit exactly CLKS_PER_BIT long.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o     = (cnt_q == C_LAST);
    assign pre_tick_o = (cnt_q == C_PRE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// uart_tx_frame : UART transmitter, start / LSB-first data / parity / stop
// Revision : 1.0
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = 3;
    localparam logic [IDX_W-1:0] C_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] C_LAST_STOP = IDX_W'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 parity_q;
    logic                 parity_d;
    logic                 tx_pin_q;
    logic                 tx_ready_q;
    logic                 tx_busy_q;
    logic                 tx_done_q;
    logic                 baud_tick;
    logic                 baud_pre_tick;

    generate
        if (PARITY == PARITY_ODD) begin : g_parity_odd
            assign parity_d = ~^tx_data;
        end else begin : g_parity_even
            assign parity_d = ^tx_data;
        end
    endgenerate

    // Holding the counter clear in IDLE makes the START bit begin at count 0.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (state_q == S_IDLE),
        .tick_o     (baud_tick),
        .pre_tick_o (baud_pre_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            parity_q   <= 1'b0;
            tx_pin_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        shreg_q    <= tx_data;
                        parity_q   <= parity_d;
                        tx_pin_q   <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        tx_pin_q <= shreg_q[0];
                        shreg_q  <= shreg_q >> 1;
                        idx_q    <= '0;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (idx_q == C_LAST_DATA) begin
                            idx_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_pin_q <= parity_q;
                                state_q  <= S_PARITY;
                            end else begin
                                tx_pin_q <= 1'b1;
                                state_q  <= S_STOP;
                            end
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            tx_pin_q <= shreg_q[0];
                            shreg_q  <= shreg_q >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        tx_pin_q <= 1'b1;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Registered done lands on the final clock of the last stop bit.
                    if (baud_pre_tick && (idx_q == C_LAST_STOP)) begin
                        tx_done_q <= 1'b1;
                    end
                    if (baud_tick) begin
                        if (idx_q == C_LAST_STOP) begin
                            tx_ready_q <= 1'b1;
                            tx_busy_q  <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_pin_q   <= 1'b1;
                    tx_ready_q <= 1'b1;
                    tx_busy_q  <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_pin   = tx_pin_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_frame : scoreboard bench over four framing configurations
// Revision : 1.0
// ============================================================================
module tb_uart_tx_frame;

    typedef struct {
        logic [7:0] d;
        int         acc;
        bit         abort;
    } ent_t;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n [NI];
    logic       valid [NI];
    logic [7:0] data  [NI];
    logic       ready [NI];
    logic       pin   [NI];
    logic       busy  [NI];
    logic       done  [NI];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_start [NI];
    int   prev_start [NI];
    ent_t sb [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(115_200), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clock(clk), .reset_n(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_pin(pin[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(115_200), .DATA_BITS(7),
                    .PARITY(0), .STOP_BITS(2)) u_dut1 (
        .clock(clk), .reset_n(rst_n[1]), .tx_data(data[1][6:0]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_pin(pin[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clock(clk), .reset_n(rst_n[2]), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_pin(pin[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(6),
                    .PARITY(1), .STOP_BITS(2)) u_dut3 (
        .clock(clk), .reset_n(rst_n[3]), .tx_data(data[3][5:0]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_pin(pin[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    function automatic int cpb_of(input int k);
        return (k < 2) ? 434 : 10;
    endfunction
    function automatic int nb_of(input int k);
        case (k) 0: return 8; 1: return 7; 2: return 8; default: return 6; endcase
    endfunction
    function automatic int par_of(input int k);
        case (k) 2: return 2; 3: return 1; default: return 0; endcase
    endfunction
    function automatic int ns_of(input int k);
        return (k == 1 || k == 3) ? 2 : 1;
    endfunction

    // Reference line level for frame bit i: start, data LSB first, parity, stops.
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int i);
        int nb   = nb_of(k);
        int ones = $countones(d);
        if (i == 0) return 1'b0;
        if (i <= nb) return d[i-1];
        if (par_of(k) != 0 && i == nb + 1)
            return (par_of(k) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, k, act, exp, $time);
    endtask

    task automatic check_frame(input int k, input ent_t e);
        int  cpb  = cpb_of(k);
        int  flen = (1 + nb_of(k) + ((par_of(k) != 0) ? 1 : 0) + ns_of(k)) * cpb;
        int  bad_bit = -1;
        int  bad_ctl = -1;
        int  done_at = -1;
        int  done_n  = 0;
        bit  aborted = 1'b0;
        prev_start[k] = last_start[k];
        last_start[k] = cyc;
        chk("start_latency", k, cyc, e.acc + 1);
        for (int c = 0; c < flen; c++) begin
            if (c != 0) @(negedge clk);
            if (rst_n[k] !== 1'b1) begin
                aborted = 1'b1;
                break;
            end
            if (bad_bit < 0 && pin[k] !== exp_bit(k, e.d, c / cpb)) bad_bit = c;
            if (bad_ctl < 0 && (busy[k] !== 1'b1 || ready[k] !== 1'b0)) bad_ctl = c;
            if (done[k] === 1'b1) begin
                done_n++;
                done_at = c;
            end
        end
        chk("frame_aborted", k, aborted, e.abort);
        chk("line_bits_first_bad_cycle", k, bad_bit, -1);
        chk("busy_ready_in_frame", k, bad_ctl, -1);
        if (!aborted) begin
            chk("done_cycle", k, done_at, flen - 1);
            chk("done_pulses", k, done_n, 1);
            @(negedge clk);
            chk("ready_busy_pin_after_done", k, {ready[k], busy[k], pin[k]}, 3'b101);
        end
    endtask

    task automatic monitor(input int k);
        forever begin
            @(negedge clk);
            if (rst_n[k] === 1'b1) begin
                if (done[k] === 1'b1) chk("stray_done", k, done[k], 0);
                if (pin[k] === 1'b0) begin
                    if (sb[k].size() == 0) begin
                        chk("frame_expected", k, sb[k].size(), 1);
                        for (int n = 0; n < 20000 && pin[k] === 1'b0; n++) @(negedge clk);
                    end else begin
                        check_frame(k, sb[k].pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
    end

    task automatic send(input int k, input logic [7:0] d, input bit abort);
        int n = 0;
        @(negedge clk);
        data[k]  = d;
        valid[k] = 1'b1;
        while (ready[k] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (ready[k] !== 1'b1) begin
            chk("accept_timeout", k, 0, 1);
            valid[k] = 1'b0;
        end else begin
            sb[k].push_back('{d & 8'((1 << nb_of(k)) - 1), cyc, abort});
            @(posedge clk);
        end
    endtask

    task automatic drop_valid(input int k);
        @(negedge clk);
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        @(negedge clk);
        while (busy[k] !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", k, busy[k], 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_run(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            send(k, 8'($urandom), 1'b0);
            if ($urandom_range(0, 2) != 0) begin
                drop_valid(k);
                repeat ($urandom_range(0, 120)) @(negedge clk);
            end
        end
        drop_valid(k);
        wait_idle(k);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0;
            valid[k] = 1'b0;
            data[k]  = 8'h00;
            last_start[k] = 0;
            prev_start[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk("reset_pin_ready_busy_done", k, {pin[k], ready[k], busy[k], done[k]}, 4'b1100);
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 0xA5, then a 0x3C pulse mid-frame that must be ignored.
        send(0, 8'hA5, 1'b0);
        drop_valid(0);
        repeat (1000) @(negedge clk);
        data[0]  = 8'h3C;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_idle(0);
        repeat (2000) @(negedge clk);
        chk("idle_line_after_ignored_pulse", 0, {pin[0], ready[0]}, 2'b11);

        // Held valid: 0x55 then 0xAA back to back.
        send(0, 8'h55, 1'b0);
        send(0, 8'hAA, 1'b0);
        drop_valid(0);
        wait_idle(0);
        chk("back_to_back_start_spacing", 0, last_start[0] - prev_start[0], 10 * 434 + 1);

        // Async reset in data bit 3 of 0xFF.
        send(0, 8'hFF, 1'b1);
        drop_valid(0);
        repeat (4 * 434 + 199) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("async_reset_pin_ready_busy", 0, {pin[0], ready[0], busy[0]}, 3'b110);
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (2000) @(negedge clk);
        chk("quiet_after_reset", 0, {pin[0], ready[0], busy[0]}, 3'b110);

        // 7N2 0x41 plus a couple of random frames.
        send(1, 8'h41, 1'b0);
        drop_valid(1);
        wait_idle(1);
        rand_run(1, 2);

        // Parity configurations: directed 0x07, then randomized traffic.
        send(2, 8'h07, 1'b0);
        drop_valid(2);
        wait_idle(2);
        rand_run(2, 30);
        send(3, 8'h07, 1'b0);
        drop_valid(3);
        wait_idle(3);
        rand_run(3, 30);

        repeat (50) @(negedge clk);
        for (int k = 0; k < NI; k++) chk("scoreboard_drained", k, sb[k].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        n_checks++;
        $display("FAIL watchdog: simulation exceeded 90000 cycles, got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
